// File: rtl/jtframe_debug_keys_pkg.sv
// Shared types and PS/2 set-2 scan-code constants for the debug-key decoder.
// Key bits 19/20 are only driven when JTFRAME_DEBUG_ALTKEYS_EN is defined.
package jtframe_debug_keys_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_t;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_KPPLUS  = 8'h79;
  localparam logic [7:0] SC_KPMINUS = 8'h7B;
  localparam logic [7:0] SC_KPSTAR  = 8'h7C;
  localparam logic [7:0] SC_F9      = 8'h01;
  localparam logic [7:0] SC_F10     = 8'h09;
  localparam logic [7:0] SC_F11     = 8'h78;
  localparam logic [7:0] SC_F12     = 8'h07;
  localparam logic [7:0] SC_D1      = 8'h16;
  localparam logic [7:0] SC_D2      = 8'h1E;
  localparam logic [7:0] SC_D3      = 8'h26;
  localparam logic [7:0] SC_D4      = 8'h25;
  localparam logic [7:0] SC_D5      = 8'h2E;
  localparam logic [7:0] SC_D6      = 8'h36;
  localparam logic [7:0] SC_D7      = 8'h3D;
  localparam logic [7:0] SC_D8      = 8'h3E;
  localparam logic [7:0] SC_EQ      = 8'h55;
  localparam logic [7:0] SC_MINUS   = 8'h4E;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Held-key vector layout; every physical source keeps its own bit.
  localparam int         NKEYS    = 21;
  localparam logic [4:0] K_LSHIFT = 5'd0;
  localparam logic [4:0] K_RSHIFT = 5'd1;
  localparam logic [4:0] K_LCTRL  = 5'd2;
  localparam logic [4:0] K_RCTRL  = 5'd3;
  localparam logic [4:0] K_PLUS   = 5'd4;
  localparam logic [4:0] K_MINUS  = 5'd5;
  localparam logic [4:0] K_STAR   = 5'd6;
  localparam logic [4:0] K_GFX0   = 5'd7;
  localparam logic [4:0] K_DIG0   = 5'd11;
  localparam logic [4:0] K_EQ     = 5'd19;
  localparam logic [4:0] K_ALTMIN = 5'd20;

endpackage

// File: rtl/jtframe_debug_keys_if.sv
// Byte stream from the PS/2 receiver into the debug-key decoder.
interface jtframe_debug_keys_if;
  logic       ps2_valid;
  logic [7:0] ps2_data;

  modport master (output ps2_valid, output ps2_data);
  modport slave  (input  ps2_valid, input  ps2_data);
endinterface

// File: rtl/jtframe_debug_keymap.sv
// Combinational scan-code lookup: {ext, code} -> one-hot key bit plus valid.
// "=" and "-" map only when JTFRAME_DEBUG_ALTKEYS_EN is defined.
module jtframe_debug_keymap
  import jtframe_debug_keys_pkg::*;
(
  input  logic             ext,
  input  logic [7:0]       code,
  output logic [NKEYS-1:0] hot,
  output logic             valid
);

  logic [4:0] idx;

  // Table lookup; fake shifts (E0 12 / E0 59) fall through as unmapped.
  always_comb begin
    idx   = 5'd0;
    valid = 1'b0;
    if (ext) begin
      if (code == SC_CTRL) begin
        idx   = K_RCTRL;
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
    end else begin
      valid = 1'b1;
      case (code)
        SC_LSHIFT:  idx = K_LSHIFT;
        SC_RSHIFT:  idx = K_RSHIFT;
        SC_CTRL:    idx = K_LCTRL;
        SC_KPPLUS:  idx = K_PLUS;
        SC_KPMINUS: idx = K_MINUS;
        SC_KPSTAR:  idx = K_STAR;
        SC_F9:      idx = K_GFX0;
        SC_F10:     idx = K_GFX0 + 5'd1;
        SC_F11:     idx = K_GFX0 + 5'd2;
        SC_F12:     idx = K_GFX0 + 5'd3;
        SC_D1:      idx = K_DIG0;
        SC_D2:      idx = K_DIG0 + 5'd1;
        SC_D3:      idx = K_DIG0 + 5'd2;
        SC_D4:      idx = K_DIG0 + 5'd3;
        SC_D5:      idx = K_DIG0 + 5'd4;
        SC_D6:      idx = K_DIG0 + 5'd5;
        SC_D7:      idx = K_DIG0 + 5'd6;
        SC_D8:      idx = K_DIG0 + 5'd7;
`ifdef JTFRAME_DEBUG_ALTKEYS_EN
        SC_EQ:      idx = K_EQ;
        SC_MINUS:   idx = K_ALTMIN;
`endif
        default:    valid = 1'b0;
      endcase
    end
  end

  // One-hot expansion of the selected index.
  always_comb begin
    hot = '0;
    if (valid) begin
      hot = {{(NKEYS-1){1'b0}}, 1'b1} << idx;
    end else begin
      hot = '0;
    end
  end

endmodule

// File: rtl/jtframe_debug_keys.sv
// PS/2 set-2 decoder producing held-key levels for the JTFRAME debug overlay.
// Optional main-keyboard +/- aliases: define JTFRAME_DEBUG_ALTKEYS_EN.
module jtframe_debug_keys
  import jtframe_debug_keys_pkg::*;
#(
  parameter int            TOW     = 24,
  parameter logic [TOW-1:0] TIMEOUT = 24'd1_000_000
)(
  input  logic                 clk,
  input  logic                 rst,
  jtframe_debug_keys_if.slave  ps2,
  output logic                 shift,
  output logic                 ctrl,
  output logic                 debug_plus,
  output logic                 debug_minus,
  output logic                 debug_rst,
  output logic [3:0]           key_gfx,
  output logic [7:0]           key_digit
);

  localparam logic [TOW-1:0] TMR_LAST = TIMEOUT - {{(TOW-1){1'b0}}, 1'b1};
  localparam logic [TOW-1:0] TMR_ONE  = {{(TOW-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt;
  logic [2:0]       skip_r, skip_nxt;
  logic [TOW-1:0]   tmr_r, tmr_nxt;
  logic [NKEYS-1:0] keys_r, keys_nxt;
  logic [NKEYS-1:0] map_hot;
  logic             map_valid;
  logic             ext;
  logic             upd;
  logic             make;

  assign ext = (state_r == ST_EXT) || (state_r == ST_EXTBRK);

  jtframe_debug_keymap u_keymap (
    .ext   (ext),
    .code  (ps2.ps2_data),
    .hot   (map_hot),
    .valid (map_valid)
  );

  // Next-state, skip/timeout counters and key update decision.
  always_comb begin
    state_nxt = state_r;
    skip_nxt  = skip_r;
    tmr_nxt   = tmr_r;
    upd       = 1'b0;
    make      = 1'b0;
    if (state_r == ST_IDLE) begin
      tmr_nxt = '0;
      if (ps2.ps2_valid) begin
        case (ps2.ps2_data)
          SC_EXT:   state_nxt = ST_EXT;
          SC_BRK:   state_nxt = ST_BRK;
          SC_PAUSE: begin
            state_nxt = ST_SKIP;
            skip_nxt  = PAUSE_SKIP;
          end
          default: begin
            upd  = 1'b1;
            make = 1'b1;
          end
        endcase
      end else begin
        state_nxt = ST_IDLE;
      end
    end else if (ps2.ps2_valid) begin
      tmr_nxt   = '0;
      state_nxt = ST_IDLE;
      case (state_r)
        ST_EXT: begin
          if (ps2.ps2_data == SC_BRK) begin
            state_nxt = ST_EXTBRK;
          end else begin
            upd  = 1'b1;
            make = 1'b1;
          end
        end
        ST_BRK, ST_EXTBRK: upd = 1'b1;
        ST_SKIP: begin
          skip_nxt = skip_r - 3'd1;
          if (skip_r != 3'd1) begin
            state_nxt = ST_SKIP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (tmr_r == TMR_LAST) begin
      // Abandoned prefix: drop it silently.
      state_nxt = ST_IDLE;
      tmr_nxt   = '0;
      skip_nxt  = 3'd0;
    end else begin
      tmr_nxt = tmr_r + TMR_ONE;
    end
  end

  // Held-key vector update for make/break codes.
  always_comb begin
    keys_nxt = keys_r;
    if (upd && map_valid) begin
      if (make) begin
        keys_nxt = keys_r | map_hot;
      end else begin
        keys_nxt = keys_r & ~map_hot;
      end
    end else begin
      keys_nxt = keys_r;
    end
  end

  // FSM, counters and key state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      skip_r  <= 3'd0;
      tmr_r   <= '0;
      keys_r  <= '0;
    end else begin
      state_r <= state_nxt;
      skip_r  <= skip_nxt;
      tmr_r   <= tmr_nxt;
      keys_r  <= keys_nxt;
    end
  end

  // Registered overlay outputs; separate sources are merged here.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= 1'b0;
      ctrl        <= 1'b0;
      debug_plus  <= 1'b0;
      debug_minus <= 1'b0;
      debug_rst   <= 1'b0;
      key_gfx     <= 4'd0;
      key_digit   <= 8'd0;
    end else begin
      shift       <= keys_nxt[K_LSHIFT] | keys_nxt[K_RSHIFT];
      ctrl        <= keys_nxt[K_LCTRL]  | keys_nxt[K_RCTRL];
      debug_plus  <= keys_nxt[K_PLUS]   | keys_nxt[K_EQ];
      debug_minus <= keys_nxt[K_MINUS]  | keys_nxt[K_ALTMIN];
      debug_rst   <= keys_nxt[K_STAR];
      key_gfx     <= keys_nxt[10:7];
      key_digit   <= keys_nxt[18:11];
    end
  end

endmodule

// File: tb/tb_jtframe_debug_keys.sv
// Self-checking bench for jtframe_debug_keys: directed plan plus random byte stream
// compared against a prefix-flag reference model. Honours JTFRAME_DEBUG_ALTKEYS_EN.
module tb_jtframe_debug_keys;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       shift, ctrl, debug_plus, debug_minus, debug_rst;
  logic [3:0] key_gfx;
  logic [7:0] key_digit;

  int checks   = 0;
  int failures = 0;

  jtframe_debug_keys_if bus ();

  jtframe_debug_keys #(.TOW(24), .TIMEOUT(24'd16)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2         (bus),
    .shift       (shift),
    .ctrl        (ctrl),
    .debug_plus  (debug_plus),
    .debug_minus (debug_minus),
    .debug_rst   (debug_rst),
    .key_gfx     (key_gfx),
    .key_digit   (key_digit)
  );

  always #5 clk = ~clk;

  // Reference model: set of held keys by name, plus pending-prefix flags.
  bit  held [string];
  bit  m_ext, m_brk;
  int  m_skip;

  function automatic string key_name(bit e, logic [7:0] c);
    if (e) return (c == 8'h14) ? "rctrl" : "";
    case (c)
      8'h12: return "lshift";   8'h59: return "rshift";
      8'h14: return "lctrl";    8'h79: return "kpplus";
      8'h7B: return "kpminus";  8'h7C: return "kpstar";
      8'h01: return "f9";       8'h09: return "f10";
      8'h78: return "f11";      8'h07: return "f12";
      8'h16: return "d1";       8'h1E: return "d2";
      8'h26: return "d3";       8'h25: return "d4";
      8'h2E: return "d5";       8'h36: return "d6";
      8'h3D: return "d7";       8'h3E: return "d8";
`ifdef JTFRAME_DEBUG_ALTKEYS_EN
      8'h55: return "eq";       8'h4E: return "minus";
`endif
      default: return "";
    endcase
  endfunction

  function automatic bit is_held(string n);
    return held.exists(n) ? held[n] : 1'b0;
  endfunction

  function automatic logic [16:0] model_out();
    string gfx [4] = '{"f9", "f10", "f11", "f12"};
    logic [16:0] o;
    o = 17'd0;
    o[16] = is_held("lshift") | is_held("rshift");
    o[15] = is_held("lctrl")  | is_held("rctrl");
    o[14] = is_held("kpplus") | is_held("eq");
    o[13] = is_held("kpminus") | is_held("minus");
    o[12] = is_held("kpstar");
    for (int i = 0; i < 4; i++) o[8+i] = is_held(gfx[i]);
    for (int i = 0; i < 8; i++) o[i] = is_held($sformatf("d%0d", i + 1));
    return o;
  endfunction

  task automatic model_byte(input logic [7:0] c);
    string n;
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk && c == 8'hE0) begin
      m_ext = 1'b1;
    end else if (!m_brk && c == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_ext && !m_brk && c == 8'hE1) begin
      m_skip = 7;
    end else begin
      n = key_name(m_ext, c);
      if (n != "") held[n] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_clear();
    held.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
  endtask

  function automatic logic [16:0] dut_out();
    return {shift, ctrl, debug_plus, debug_minus, debug_rst, key_gfx, key_digit};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe one byte (called on a negedge); returns on the following negedge.
  task automatic put(input logic [7:0] c);
    bus.ps2_valid = 1'b1;
    bus.ps2_data  = c;
    @(negedge clk);
    model_byte(c);
    bus.ps2_valid = 1'b0;
  endtask

  task automatic put_chk(input logic [7:0] c, input string tag, input logic [16:0] exp);
    put(c);
    check_val(tag, {15'd0, dut_out()}, {15'd0, exp});
    check_val({tag, "_model"}, {15'd0, dut_out()}, {15'd0, model_out()});
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    bus.ps2_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [7:0] pool [24] = '{8'h12, 8'h59, 8'h14, 8'h79, 8'h7B, 8'h7C, 8'h01, 8'h09,
                              8'h78, 8'h07, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h55, 8'h4E, 8'hE0, 8'hF0, 8'hF0, 8'hE1};
    logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] b;
    rst = 1'b1;
    bus.ps2_valid = 1'b0;
    bus.ps2_data  = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {15'd0, dut_out()}, 32'd0);
    rst = 1'b0;

    // 1: shift make/break
    put_chk(8'h12, "lshift_make", 17'h10000);
    put_chk(8'hF0, "lshift_brk_prefix", 17'h10000);
    put_chk(8'h12, "lshift_break", 17'h00000);

    // 2: digits and typematic
    put_chk(8'h16, "d1_make", 17'h00001);
    put_chk(8'h3E, "d8_make", 17'h00081);
    put(8'hF0);
    put_chk(8'h16, "d1_break", 17'h00080);
    for (int i = 0; i < 3; i++) put_chk(8'h3E, "d8_typematic", 17'h00080);

    // 3: ctrl sources and fake shift
    put(8'hE0);
    put_chk(8'h14, "rctrl_make", 17'h08080);
    put_chk(8'h14, "lctrl_make", 17'h08080);
    put(8'hE0); put(8'hF0);
    put_chk(8'h14, "rctrl_break_lctrl_held", 17'h08080);
    put(8'hF0);
    put_chk(8'h14, "lctrl_break", 17'h00080);
    put(8'hE0);
    put_chk(8'h12, "fake_shift", 17'h00080);

    // 4: pause sequence swallowed
    for (int i = 0; i < 8; i++) put_chk(pause[i], "pause_seq", 17'h00080);
    put_chk(8'h79, "kpplus_after_pause", 17'h04080);

    // 5: break prefix times out
    put(8'hF0);
    repeat (TMO + 2) @(negedge clk);
    m_brk = 1'b0;
    put_chk(8'h01, "f9_after_timeout", 17'h04180);

    // 6: reset mid-sequence
    put(8'h12); put(8'h79); put(8'h07);
    check_val("held_before_rst", {15'd0, dut_out()}, {15'd0, 17'h14980});
    put(8'hE0);
    pulse_rst();
    check_val("rst_mid_seq", {15'd0, dut_out()}, 32'd0);
    put_chk(8'h7B, "kpminus_after_rst", 17'h02000);
`ifdef JTFRAME_DEBUG_ALTKEYS_EN
    put_chk(8'h55, "alt_eq", 17'h06000);
`else
    put_chk(8'h55, "alt_eq", 17'h02000);
`endif

    // Random stream against the model; gaps stay well below the timeout.
    pulse_rst();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 27) < 24) b = pool[$urandom_range(0, 23)];
      else b = 8'($urandom);
      put(b);
      check_val($sformatf("rand_%0d_%02h", i, b), {15'd0, dut_out()}, {15'd0, model_out()});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
